// File: rtl/port_mux_arb.sv
// port_mux_arb
// Merges NPORT receive (descriptor FIFO, data FIFO) pairs into a single
// output byte stream plus descriptor stream. One whole frame is moved per
// grant: pop the descriptor, stream its L bytes, then write the descriptor
// with bits [15:12] replaced by the source port number.
// Port selection is round-robin. Defining the macro WRR_EN turns it into
// weighted round-robin: a port may keep the grant for up to weight+1
// consecutive frames.
// Zero-length descriptors are popped and dropped and counted in drop_cnt.
module port_mux_arb #(
    parameter int NPORT = 4,
    parameter int DW    = 8,
    parameter int PTRW  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NPORT-1:0]      rx_ptr_fifo_empty,
    output logic [NPORT-1:0]      rx_ptr_fifo_rd,
    input  logic [NPORT*PTRW-1:0] rx_ptr_fifo_dout,
    output logic [NPORT-1:0]      rx_data_fifo_rd,
    input  logic [NPORT*DW-1:0]   rx_data_fifo_dout,
    input  logic                  out_afull,
    output logic [DW-1:0]         data_out,
    output logic                  data_wr,
    output logic [PTRW-1:0]       ptr_out,
    output logic                  ptr_wr,
    input  logic [NPORT*4-1:0]    weight,
    output logic [15:0]           drop_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_PTR = 3'd1;
    localparam logic [2:0] S_LATCH  = 3'd2;
    localparam logic [2:0] S_XFER   = 3'd3;
    localparam logic [2:0] S_FLUSH  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [3:0] LAST_PORT = 4'(NPORT - 1);

    logic [2:0]      state_r;
    logic [2:0]      next_state_s;
    logic [3:0]      grant_r;
    logic [3:0]      last_grant_r;
    logic [11:0]     cnt_r;
    logic [PTRW-1:0] desc_r;
    logic [15:0]     req_s;
    logic [3:0]      pick_s;
    logic            pick_valid_s;
    logic [PTRW-1:0] desc_sel_s;
    logic [DW-1:0]   data_sel_s;
    logic [11:0]     len_s;

`ifdef WRR_EN
    logic [3:0]      credit_r;
    logic [3:0]      weight_sel_s;
`else
    logic            unused_weight;
    assign unused_weight = ^weight;
`endif

    // One-hot strobe vector for a port index.
    function automatic logic [NPORT-1:0] port_onehot(input logic [3:0] idx);
        logic [NPORT-1:0] v;
        v = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (idx == i[3:0]) begin
                v[i] = 1'b1;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    // Outgoing descriptor: captured descriptor with the source port in [15:12].
    function automatic logic [PTRW-1:0] ptr_fmt(input logic [PTRW-1:0] desc,
                                                 input logic [3:0]      port);
        logic [PTRW-1:0] p;
        p        = desc;
        p[15:12] = port;
        return p;
    endfunction

    // Request vector widened to 16 bits so any 4-bit port index is in range.
    always_comb begin
        req_s              = 16'h0000;
        req_s[NPORT-1:0]   = ~rx_ptr_fifo_empty;
    end

    // Circular search from last_grant+1; the first requesting port wins.
    always_comb begin : rr_pick
        int         idx;
        logic [3:0] cand;
        pick_s       = last_grant_r;
        pick_valid_s = 1'b0;
        for (int off = 1; off <= NPORT; off++) begin
            idx = int'(last_grant_r) + off;
            if (idx >= NPORT) begin
                idx = idx - NPORT;
            end else begin
                idx = idx;
            end
            cand = idx[3:0];
            if (!pick_valid_s && req_s[cand]) begin
                pick_s       = cand;
                pick_valid_s = 1'b1;
            end else begin
                pick_valid_s = pick_valid_s;
            end
        end
    end

    // Select the granted port's descriptor, data byte and weight.
    always_comb begin
        desc_sel_s = '0;
        data_sel_s = '0;
`ifdef WRR_EN
        weight_sel_s = 4'd0;
`endif
        for (int i = 0; i < NPORT; i++) begin
            if (grant_r == i[3:0]) begin
                desc_sel_s = rx_ptr_fifo_dout[i*PTRW +: PTRW];
                data_sel_s = rx_data_fifo_dout[i*DW +: DW];
`ifdef WRR_EN
                weight_sel_s = weight[i*4 +: 4];
`endif
            end else begin
                desc_sel_s = desc_sel_s;
            end
        end
    end

    assign len_s = desc_sel_s[11:0];

    // Next-state logic; out_afull only gates the start of a new frame.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (pick_valid_s && !out_afull) begin
                    next_state_s = S_RD_PTR;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_RD_PTR: next_state_s = S_LATCH;
            S_LATCH: begin
                if (len_s == 12'd0) begin
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_XFER;
                end
            end
            S_XFER: begin
                if (cnt_r == 12'd1) begin
                    next_state_s = S_FLUSH;
                end else begin
                    next_state_s = S_XFER;
                end
            end
            S_FLUSH: next_state_s = S_DONE;
            S_DONE:  next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // State register and grant capture at the IDLE decision point.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            grant_r <= 4'd0;
        end else begin
            state_r <= next_state_s;
            if (state_r == S_IDLE) begin
                grant_r <= pick_s;
            end else begin
                grant_r <= grant_r;
            end
        end
    end

    // Registered FIFO pops and output write strobes, aligned to the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ptr_fifo_rd  <= '0;
            rx_data_fifo_rd <= '0;
            data_wr         <= 1'b0;
            ptr_wr          <= 1'b0;
        end else begin
            rx_ptr_fifo_rd  <= (state_r == S_IDLE && next_state_s == S_RD_PTR) ?
                               port_onehot(pick_s) : '0;
            rx_data_fifo_rd <= (next_state_s == S_XFER) ? port_onehot(grant_r) : '0;
            data_wr         <= |rx_data_fifo_rd;
            ptr_wr          <= (next_state_s == S_DONE);
        end
    end

    // Descriptor capture, byte down-counter and outgoing descriptor register.
    always_ff @(posedge clk) begin
        if (rst) begin
            desc_r  <= '0;
            cnt_r   <= 12'd0;
            ptr_out <= '0;
        end else begin
            if (state_r == S_LATCH) begin
                desc_r <= desc_sel_s;
                cnt_r  <= len_s;
            end else if (state_r == S_XFER) begin
                cnt_r  <= cnt_r - 12'd1;
            end else begin
                cnt_r  <= cnt_r;
            end
            if (next_state_s == S_DONE) begin
                ptr_out <= ptr_fmt(desc_r, grant_r);
            end else begin
                ptr_out <= ptr_out;
            end
        end
    end

    // Arbitration history, WRR credit and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= LAST_PORT;
            drop_cnt     <= 16'h0000;
`ifdef WRR_EN
            credit_r     <= 4'd0;
`endif
        end else if (state_r == S_LATCH && len_s == 12'd0) begin
            last_grant_r <= grant_r;
            if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end else begin
                drop_cnt <= drop_cnt;
            end
`ifdef WRR_EN
            credit_r     <= 4'd0;
`endif
        end else if (state_r == S_DONE) begin
`ifdef WRR_EN
            // Staying on the same port: point the search just before it.
            if (credit_r < weight_sel_s && req_s[grant_r]) begin
                credit_r     <= credit_r + 4'd1;
                last_grant_r <= (grant_r == 4'd0) ? LAST_PORT : grant_r - 4'd1;
            end else begin
                credit_r     <= 4'd0;
                last_grant_r <= grant_r;
            end
`else
            last_grant_r <= grant_r;
`endif
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Byte lane follows the data FIFO output of the granted port while writing.
    always_comb begin
        if (data_wr) begin
            data_out = data_sel_s;
        end else begin
            data_out = '0;
        end
    end

endmodule

// File: tb/tb_port_mux_arb.sv
// Self-checking bench for port_mux_arb: FIFO models per port, a frame-level
// reference model evaluated every cycle, directed scenarios and random traffic.
module tb_port_mux_arb;

    localparam int NP = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] fifo_empty = 4'hF;
    logic [NP-1:0] rx_ptr_fifo_rd;
    logic [NP*16-1:0] ptr_dout = '0;
    logic [NP-1:0] rx_data_fifo_rd;
    logic [NP*8-1:0] data_dout = '0;
    logic          out_afull = 1'b0;
    logic [7:0]    data_out;
    logic          data_wr;
    logic [15:0]   ptr_out;
    logic          ptr_wr;
    logic [NP*4-1:0] weight = '0;
    logic [15:0]   drop_cnt;

    port_mux_arb #(.NPORT(NP), .DW(8), .PTRW(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .rx_ptr_fifo_empty (fifo_empty),
        .rx_ptr_fifo_rd    (rx_ptr_fifo_rd),
        .rx_ptr_fifo_dout  (ptr_dout),
        .rx_data_fifo_rd   (rx_data_fifo_rd),
        .rx_data_fifo_dout (data_dout),
        .out_afull         (out_afull),
        .data_out          (data_out),
        .data_wr           (data_wr),
        .ptr_out           (ptr_out),
        .ptr_wr            (ptr_wr),
        .weight            (weight),
        .drop_cnt          (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef logic [15:0] descq_t [$];
    typedef logic [7:0]  byteq_t [$];
    descq_t pq [NP];
    byteq_t dq [NP];

    int n_cmp = 0;
    int n_bad = 0;

    // Observation logs.
    logic [15:0] plog [$];
    int          slog [$];
    int          cyc = 0, rd_cyc = 0, dwr_n = 0, prd_n = 0;

    // Reference model state.
    bit          mbusy = 1'b0, mpend = 1'b0;
    int          mk = 0, mg = 0, ml = 0, mlast = NP - 1, mhold = -1, mcredit = 0, mdrop = 0;
    logic [15:0] mdesc = '0;
    logic [7:0]  mbytes [$];

`ifdef WRR_EN
    int ord [12] = '{0, 0, 0, 1, 2, 3, 0, 0, 0, 1, 2, 3};
`else
    int ord [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_frame(input int p, input int len);
        logic [3:0] junk;
        junk = 4'($urandom);
        pq[p].push_back({junk, 12'(len)});
        for (int j = 0; j < len; j++) dq[p].push_back(8'($urandom));
    endtask

    function automatic logic [15:0] plog_at(input int i);
        if (i < plog.size()) return plog[i];
        return 16'hDEAD;
    endfunction

    task automatic wait_ptr(input int n, input int budget);
        int t = 0;
        while (plog.size() < n && t < budget) begin
            tick(1);
            t++;
        end
        if (plog.size() < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_ptr timeout: got %0d ptr_wr, expected %0d", plog.size(), n);
        end
    endtask

    task automatic wait_idle(input int budget);
        int  t = 0;
        bit  pending = 1'b1;
        while (pending && t < budget) begin
            tick(1);
            t++;
            pending = mbusy || mpend;
            for (int i = 0; i < NP; i++) if (pq[i].size() != 0) pending = 1'b1;
        end
        if (pending) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idle timeout: got busy, expected drained");
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    // Source FIFO models: pop on the sampled rd strobe, dout valid next cycle.
    always @(posedge clk) begin
        logic [NP-1:0] e;
        for (int i = 0; i < NP; i++) begin
            if (rx_ptr_fifo_rd[i] && pq[i].size() > 0) ptr_dout[i*16 +: 16] <= pq[i].pop_front();
            if (rx_data_fifo_rd[i] && dq[i].size() > 0) data_dout[i*8 +: 8] <= dq[i].pop_front();
            e[i] = (pq[i].size() == 0);
        end
        fifo_empty <= e;
    end

    // Frame-level reference model and per-cycle compare.
    initial begin : compare
        bit          rst_seen;
        logic [NP-1:0] req, e_prd, e_drd;
        bit          e_dwr, e_pwr;
        forever begin
            @(posedge clk);
            rst_seen = rst;
            @(negedge clk);
            cyc++;
            if (rst_seen) begin
                mbusy = 0; mpend = 0; mlast = NP - 1; mhold = -1; mcredit = 0; mdrop = 0;
            end else begin
                if (mpend) begin
                    mbusy = 1; mk = 0; mpend = 0;
                end else if (mbusy) begin
                    mk++;
                end
                if (mbusy && ml == 0 && mk == 1) begin
                    mlast = mg; mcredit = 0; mhold = -1;
                end
                if (mbusy && ml == 0 && mk == 2) begin
                    mbusy = 0;
                    if (mdrop < 65535) mdrop++;
                end
                if (mbusy && ml > 0 && mk == ml + 3) begin
`ifdef WRR_EN
                    if (mcredit < int'(weight[mg*4 +: 4]) && !fifo_empty[mg]) begin
                        mcredit++; mhold = mg;
                    end else begin
                        mcredit = 0; mhold = -1; mlast = mg;
                    end
`else
                    mlast = mg;
`endif
                end
                if (mbusy && ml > 0 && mk == ml + 4) mbusy = 0;
            end
            e_prd = (mbusy && mk == 0) ? NP'(1 << mg) : '0;
            e_drd = (mbusy && ml > 0 && mk >= 2 && mk <= ml + 1) ? NP'(1 << mg) : '0;
            e_dwr = mbusy && ml > 0 && mk >= 3 && mk <= ml + 2;
            e_pwr = mbusy && ml > 0 && mk == ml + 3;
            chk("ptr_rd", rx_ptr_fifo_rd, e_prd);
            chk("data_rd", rx_data_fifo_rd, e_drd);
            chk("data_wr", data_wr, e_dwr);
            chk("ptr_wr", ptr_wr, e_pwr);
            chk("drop_cnt", drop_cnt, mdrop[15:0]);
            if (e_dwr && (mk - 3) < mbytes.size()) chk("data_out", data_out, mbytes[mk-3]);
            if (e_pwr) chk("ptr_out", ptr_out, {4'(mg), mdesc[11:0]});
            if (ptr_wr) begin
                plog.push_back(ptr_out);
                slog.push_back(cyc - rd_cyc + 1);
            end
            if (|rx_ptr_fifo_rd) begin
                rd_cyc = cyc;
                prd_n++;
            end
            if (data_wr) dwr_n++;
            if (!mbusy) begin
                req = ~fifo_empty;
                if (req != '0 && !out_afull) begin
                    if (mhold >= 0 && req[mhold]) begin
                        mg = mhold;
                    end else begin
                        for (int off = NP; off >= 1; off--)
                            if (req[(mlast + off) % NP]) mg = (mlast + off) % NP;
                    end
                    mhold = -1;
                    mdesc = pq[mg][0];
                    ml = int'(mdesc[11:0]);
                    mbytes.delete();
                    for (int j = 0; j < ml && j < dq[mg].size(); j++) mbytes.push_back(dq[mg][j]);
                    mpend = 1;
                end
            end
        end
    end

    initial begin : stim
        int b, d0, p0, t;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("reset_drop", drop_cnt, 32'd0);
        chk("reset_strobes", {rx_ptr_fifo_rd, rx_data_fifo_rd, data_wr, ptr_wr}, 32'd0);

        // Single frame, port 2, L=5.
        b = plog.size(); d0 = dwr_n;
        push_frame(2, 5);
        wait_ptr(b + 1, 100);
        chk("t1_ptr", plog_at(b), 32'h2005);
        if (b < slog.size()) chk("t1_span", slog[b], 32'd9);
        chk("t1_bytes", dwr_n - d0, 32'd5);
        wait_idle(200);

        // Fairness / weighted order.
        do_reset();
        b = plog.size();
`ifdef WRR_EN
        weight = 16'h0002;
        for (int f = 0; f < 3; f++) push_frame(0, $urandom_range(1, 6));
`endif
        for (int f = 0; f < 3; f++)
            for (int p = 0; p < NP; p++) push_frame(p, $urandom_range(1, 6));
`ifdef WRR_EN
        wait_ptr(b + 15, 1000);
`else
        wait_ptr(b + 12, 1000);
`endif
        for (int i = 0; i < 12; i++) chk("t2_order", plog_at(b + i) >> 12, ord[i]);
        wait_idle(500);
        weight = '0;

        // Backpressure before start and mid-frame.
        out_afull = 1'b1;
        push_frame(1, 3);
        push_frame(3, 4);
        p0 = prd_n;
        tick(6);
        chk("t3_no_rd", prd_n - p0, 32'd0);
        out_afull = 1'b0;
        tick(1);
        chk("t3_release", rx_ptr_fifo_rd, 32'h2);
        wait_idle(200);
        b = plog.size(); d0 = dwr_n;
        push_frame(0, 10);
        t = 0;
        while (dwr_n < d0 + 2 && t < 100) begin tick(1); t++; end
        out_afull = 1'b1;
        wait_ptr(b + 1, 100);
        chk("t3_complete", plog_at(b), 32'h000A);
        out_afull = 1'b0;
        wait_idle(200);

        // Zero-length descriptor is dropped.
        do_reset();
        b = plog.size(); d0 = dwr_n;
        push_frame(1, 0);
        push_frame(2, 3);
        wait_ptr(b + 1, 100);
        chk("t4_drop", drop_cnt, 32'd1);
        chk("t4_next", plog_at(b), 32'h2003);
        chk("t4_bytes", dwr_n - d0, 32'd3);
        wait_idle(200);

        // Reset in the middle of a transfer.
        do_reset();
        b = plog.size(); d0 = dwr_n;
        push_frame(0, 10);
        push_frame(0, 2);
        push_frame(3, 4);
        t = 0;
        while (dwr_n < d0 + 3 && t < 100) begin tick(1); t++; end
        rst = 1'b1;
        tick(1);
        chk("t5_strobes", {rx_ptr_fifo_rd, rx_data_fifo_rd, data_wr, ptr_wr}, 32'd0);
        rst = 1'b0;
        wait_ptr(b + 1, 100);
        chk("t5_first", plog_at(b), 32'h0002);
        wait_idle(300);

        // Random traffic.
        do_reset();
        for (int it = 0; it < 300; it++) begin
            tick($urandom_range(0, 4));
            if ($urandom_range(0, 3) != 0)
                push_frame($urandom_range(0, NP - 1),
                           ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12));
            if ($urandom_range(0, 7) == 0) out_afull = ~out_afull;
            if (it % 50 == 0) weight = 16'($urandom);
        end
        out_afull = 1'b0;
        wait_idle(20000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/port_mux_arb.md
PORT_MUX_ARB -- requirements
Module: port_mux_arb

Interface
REQ-001 Parameter NPORT, default 4: number of receive ports, legal range 2..16.
REQ-002 Parameter DW, default 8: data byte-lane width.
REQ-003 Parameter PTRW, default 16: descriptor width; bits [11:0] hold the frame length in bytes, bits [15:12] are rewritten by this block.
REQ-004 Port clk  in  1: the single clock; all logic is rising-edge.
REQ-005 Port rst  in  1: synchronous, active-high reset.
REQ-006 Port rx_ptr_fifo_empty  in  NPORT: per-port descriptor FIFO empty flag.
REQ-007 Port rx_ptr_fifo_rd  out  NPORT: per-port descriptor pop; dout is valid on the following cycle.
REQ-008 Port rx_ptr_fifo_dout  in  NPORT*PTRW: per-port descriptors; port i occupies slice [i*PTRW +: PTRW].
REQ-009 Port rx_data_fifo_rd  out  NPORT: per-port data pop; dout is valid on the following cycle.
REQ-010 Port rx_data_fifo_dout  in  NPORT*DW: per-port data; port i occupies slice [i*DW +: DW].
REQ-011 Port out_afull  in  1: downstream almost-full; it can absorb one more maximum-size frame.
REQ-012 Port data_out / data_wr  out  DW / 1: merged byte stream and its write strobe.
REQ-013 Port ptr_out / ptr_wr  out  PTRW / 1: merged descriptor and its write strobe.
REQ-014 Port weight  in  NPORT*4: per-port WRR weight; used only under WRR_EN.
REQ-015 Port drop_cnt  out  16: count of dropped zero-length descriptors.

Function
REQ-016 FSM states: IDLE, RD_PTR, LATCH, XFER, FLUSH, DONE.
REQ-017 IDLE: when the request vector (~rx_ptr_fifo_empty) is nonzero and out_afull=0, select a port per REQ-023 and go to RD_PTR; otherwise stay in IDLE.
REQ-018 out_afull is sampled only in IDLE; a frame in progress always completes.
REQ-019 RD_PTR: assert rx_ptr_fifo_rd[g] for exactly one cycle, then go to LATCH.
REQ-020 LATCH: capture the descriptor and load a 12-bit down-counter with length L.
  - L=0: go to IDLE; no data read; no ptr_wr; drop_cnt increments and saturates at 16'hFFFF.
  - L>0: go to XFER.
REQ-021 XFER: assert rx_data_fifo_rd[g] for exactly L consecutive cycles, then go to FLUSH.
  - data_wr follows one cycle after each rd, so it is high for exactly L consecutive cycles.
  - data_out carries the registered slice of port g.
REQ-022 FLUSH: last data_wr cycle; go to DONE. DONE: ptr_wr=1 for one cycle, with ptr_out = captured descriptor with bits [15:12]=g; then go to IDLE.
REQ-023 Round-robin: search the request vector circularly from last_grant+1; the first requester wins; last_grant<=g at DONE or at a drop.
REQ-024 Only port g's rd strobes are ever asserted; all other bits are 0.
REQ-025 Frame cycle count from RD_PTR through DONE = L+4; minimum back-to-back spacing is one IDLE cycle.
REQ-026 Ports that request during a frame are considered at the next IDLE only.

Reset
REQ-027 While rst=1:
  - state=IDLE; last_grant=NPORT-1, so port 0 has first priority.
  - all rd strobes, data_wr and ptr_wr are 0; data_out, ptr_out and drop_cnt are 0; WRR credits are 0.
REQ-028 A reset mid-frame aborts the frame; no ptr_wr is issued for it, and remaining bytes stay in the source FIFO.

Configuration
REQ-029 Macro WRR_EN selects weighted round-robin.
  - Defined: at DONE, if credit<weight[g] and port g still requests, keep g and increment credit; otherwise reset credit to 0 and rotate per REQ-023.
  - Each port thus sends up to weight+1 consecutive frames.
REQ-030 WRR_EN undefined: pure round-robin; the weight input is ignored and no credit logic is built.

Verification
REQ-031 Single frame: port 2 descriptor L=5 -> rx_ptr_fifo_rd[2] for 1 cycle, 5 data_wr with matching bytes, then ptr_wr with ptr_out[15:12]=2, [11:0]=5; 9 cycles from RD_PTR through DONE.
REQ-032 Fairness: all 4 ports hold 3 frames each, WRR_EN undefined -> grant order 0,1,2,3,0,1,2,3,...; 12 ptr_wr total.
REQ-033 Backpressure: out_afull=1 while requests are pending -> no rd strobes; out_afull deasserted -> RD_PTR on the next cycle. out_afull raised mid-XFER -> frame completes.
REQ-034 Zero length: port 1 descriptor L=0 -> ptr popped, no data_wr, no ptr_wr, drop_cnt=1; next requester served.
REQ-035 Reset mid-XFER at byte 3 of L=10 -> all strobes 0 on the next cycle, no ptr_wr, port 0 served first afterwards.
REQ-036 WRR_EN defined, weight0=2, others 0, all ports busy -> order 0,0,0,1,2,3,0,0,0,...
